// File: rtl/fm2151_pkg.sv
// rtl/fm2151_pkg.sv - shared state encoding, bus constants and default timing for the fm2151 write queue
// Contents:
//   wrq_state_t      write-queue sequencer states
//   A0_ADDR/A0_DATA  OPM A0 levels for address and data strobes
//   STATUS_BUSY_BIT  BUSY bit position in the OPM status byte
//   DEF_*            default timing constants shared with fm2151 (clk cycles at 48 MHz, phiM = clk/14)
//   cyc_max          largest of four cycle counts, used to size the shared down-counter
package fm2151_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_ADDR_WR  = 3'd2,
        ST_GAP      = 3'd3,
        ST_DATA_WR  = 3'd4,
        ST_SETTLE   = 3'd5
    } wrq_state_t;

    localparam logic A0_ADDR         = 1'b0;
    localparam logic A0_DATA         = 1'b1;
    localparam int   STATUS_BUSY_BIT = 7;

    localparam int DEF_WRQ_DEPTH   = 16;
    localparam int DEF_STROBE_CYC  = 28;
    localparam int DEF_GAP_CYC     = 14;
    localparam int DEF_SETTLE_CYC  = 64;
    localparam int DEF_TIMEOUT_CYC = 4096;

    function automatic int cyc_max(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/fm2151_wrq_fifo.sv
// rtl/fm2151_wrq_fifo.sv - synchronous FIFO holding {register, value} pairs, with occupancy and one-cycle flush
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   wr_en        write wr_data (caller guarantees !full and no flush)
//   wr_data      entry to store
//   rd_en        drop the head entry (caller guarantees !empty)
//   rd_data      head entry, valid whenever !empty
//   flush        discard all stored entries this cycle; overrides wr_en/rd_en
//   full, empty  occupancy flags
//   level        number of stored entries, 0..DEPTH
module fm2151_wrq_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);

endmodule

// File: rtl/fm2151_wrq.sv
// rtl/fm2151_wrq.sv - write-queue sequencer replaying queued (register, value) pairs onto the OPM bus
// Optional feature: define FM2151_WRQ_TIMEOUT_EN to add the BUSY watchdog and err_timeout_o.
// Ports:
//   clk, reset                 48 MHz clock, asynchronous active-high reset
//   wq_addr_i, wq_data_i       pair to queue
//   wq_valid_i, wq_ready_o     push handshake (push on valid & ready)
//   wq_flush_i                 drop queued entries; the pair already being replayed finishes
//   wq_level_o                 queue occupancy
//   wq_idle_o                  queue empty and sequencer idle
//   opm_cs_n_o, opm_wr_n_o     registered OPM chip select / write strobe, active low
//   opm_a0_o, opm_d_o          OPM A0 and write data
//   opm_status_i               OPM status byte, bit 7 = BUSY
//   err_timeout_o              sticky watchdog flag (constant 0 without the watchdog)
module fm2151_wrq
    import fm2151_pkg::*;
#(
    parameter int DEPTH       = DEF_WRQ_DEPTH,
    parameter int STROBE_CYC  = DEF_STROBE_CYC,
    parameter int GAP_CYC     = DEF_GAP_CYC,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              wq_addr_i,
    input  logic [7:0]              wq_data_i,
    input  logic                    wq_valid_i,
    output logic                    wq_ready_o,
    input  logic                    wq_flush_i,
    output logic [$clog2(DEPTH):0]  wq_level_o,
    output logic                    wq_idle_o,
    output logic                    opm_cs_n_o,
    output logic                    opm_wr_n_o,
    output logic                    opm_a0_o,
    output logic [7:0]              opm_d_o,
    input  logic [7:0]              opm_status_i,
    output logic                    err_timeout_o
);

    localparam int CNT_MAX = cyc_max(STROBE_CYC, GAP_CYC, SETTLE_CYC, TIMEOUT_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Counter reload values: a state lasting N cycles is entered with N-1 and left at 0.
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
`ifdef FM2151_WRQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYC - 1);
`endif

    wrq_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             cs_n_q, cs_n_nxt;
    logic             wr_n_q, wr_n_nxt;
    logic             a0_q, a0_nxt;
    logic [7:0]       d_q, d_nxt;
    logic [7:0]       hold_data_q, hold_data_nxt;

    logic             push;
    logic             pop;
    logic [15:0]      fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             busy;

    assign busy       = opm_status_i[STATUS_BUSY_BIT];
    assign wq_ready_o = !fifo_full && !wq_flush_i;
    assign push       = wq_valid_i && wq_ready_o;
    assign wq_idle_o  = fifo_empty && (state == ST_IDLE);

    fm2151_wrq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .wr_en   (push),
        .wr_data ({wq_addr_i, wq_data_i}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .flush   (wq_flush_i),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (wq_level_o)
    );

`ifdef FM2151_WRQ_TIMEOUT_EN
    logic err_set;
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
    end

    assign err_timeout_o = err_q;
`else
    assign err_timeout_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cs_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            a0_q        <= A0_ADDR;
            d_q         <= 8'h00;
            hold_data_q <= 8'h00;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cs_n_q      <= cs_n_nxt;
            wr_n_q      <= wr_n_nxt;
            a0_q        <= a0_nxt;
            d_q         <= d_nxt;
            hold_data_q <= hold_data_nxt;
        end
    end

    // Bus outputs are registered from the next-state decode so cs_n falls in the
    // same cycle the strobe state is entered. The address is placed on the bus at
    // pop time, well before cs_n falls; the data byte is only presented when the
    // data strobe starts, so the gap keeps showing the address.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        cs_n_nxt      = cs_n_q;
        wr_n_nxt      = wr_n_q;
        a0_nxt        = a0_q;
        d_nxt         = d_q;
        hold_data_nxt = hold_data_q;
        pop           = 1'b0;
`ifdef FM2151_WRQ_TIMEOUT_EN
        err_set       = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                // A flush in the same cycle wins: nothing is taken from the queue.
                if (!fifo_empty && !wq_flush_i) begin
                    pop           = 1'b1;
                    hold_data_nxt = fifo_rd_data[7:0];
                    a0_nxt        = A0_ADDR;
                    d_nxt         = fifo_rd_data[15:8];
                    state_nxt     = ST_WAIT_RDY;
`ifdef FM2151_WRQ_TIMEOUT_EN
                    cnt_nxt       = TIMEOUT_LD;
`endif
                end
            end
            ST_WAIT_RDY: begin
                if (!busy) begin
                    state_nxt = ST_ADDR_WR;
                    cnt_nxt   = STROBE_LD;
                    cs_n_nxt  = 1'b0;
                    wr_n_nxt  = 1'b0;
                end
`ifdef FM2151_WRQ_TIMEOUT_EN
                else if (cnt == '0) begin
                    // Chip never became ready: drop the held pair without touching the bus.
                    state_nxt = ST_IDLE;
                    err_set   = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
`endif
            end
            ST_ADDR_WR: begin
                if (cnt == '0) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = GAP_LD;
                    cs_n_nxt  = 1'b1;
                    wr_n_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_nxt = ST_DATA_WR;
                    cnt_nxt   = STROBE_LD;
                    cs_n_nxt  = 1'b0;
                    wr_n_nxt  = 1'b0;
                    a0_nxt    = A0_DATA;
                    d_nxt     = hold_data_q;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_DATA_WR: begin
                if (cnt == '0) begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = SETTLE_LD;
                    cs_n_nxt  = 1'b1;
                    wr_n_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_SETTLE: begin
                // BUSY is not valid yet right after a data write; just wait it out.
                if (cnt == '0) state_nxt = ST_IDLE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
                cs_n_nxt  = 1'b1;
                wr_n_nxt  = 1'b1;
            end
        endcase
    end

    assign opm_cs_n_o = cs_n_q;
    assign opm_wr_n_o = wr_n_q;
    assign opm_a0_o   = a0_q;
    assign opm_d_o    = d_q;

    logic unused_status;
    assign unused_status = ^opm_status_i;

endmodule

// File: tb/tb_fm2151_wrq.sv
// tb/tb_fm2151_wrq.sv - self-checking bench for fm2151_wrq (bus-strobe monitor plus pair-order model)
module tb_fm2151_wrq;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] addr;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       flush;
    logic [4:0] level;
    logic       idle;
    logic       cs_n;
    logic       wr_n;
    logic       a0;
    logic [7:0] d;
    logic [7:0] status = 8'h00;
    logic       err;

    fm2151_wrq dut (
        .clk           (clk),
        .reset         (rst),
        .wq_addr_i     (addr),
        .wq_data_i     (data),
        .wq_valid_i    (valid),
        .wq_ready_o    (ready),
        .wq_flush_i    (flush),
        .wq_level_o    (level),
        .wq_idle_o     (idle),
        .opm_cs_n_o    (cs_n),
        .opm_wr_n_o    (wr_n),
        .opm_a0_o      (a0),
        .opm_d_o       (d),
        .opm_status_i  (status),
        .err_timeout_o (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: every cs_n low window becomes one strobe record.
    typedef struct {
        int         start;
        int         len;
        logic       a0;
        logic [7:0] d;
        int         fall;
    } strobe_t;

    strobe_t    sq[$];
    strobe_t    cur;
    logic       prev_cs = 1'b1;
    logic       prev_a0 = 1'b0;
    logic [7:0] prev_d  = 8'h00;
    int         stab_bad = 0;
    logic       busy_force = 1'b0;
    logic       busy_auto  = 1'b0;
    int         busy_hold  = 0;
    logic       busy_now;
    logic       busy_prev  = 1'b0;
    int         last_fall  = -1;

    always @(posedge clk) begin
        #1;
        if (!cs_n) begin
            if (prev_cs) begin
                cur.start = cyc;
                cur.len   = 1;
                cur.a0    = a0;
                cur.d     = d;
                cur.fall  = last_fall;
            end else begin
                cur.len++;
                if (a0 !== cur.a0 || d !== cur.d) stab_bad++;
            end
            if (wr_n !== 1'b0) stab_bad++;
        end else begin
            if (wr_n !== 1'b1) stab_bad++;
            if (!prev_cs) begin
                if (!rst && (a0 !== prev_a0 || d !== prev_d)) stab_bad++;
                sq.push_back(cur);
                if (busy_auto && cur.a0) busy_hold = 200;
            end
        end
        prev_cs = cs_n;
        prev_a0 = a0;
        prev_d  = d;
        busy_now = busy_force || (busy_hold > 0);
        if (busy_hold > 0) busy_hold--;
        if (busy_prev && !busy_now) last_fall = cyc;
        busy_prev = busy_now;
        status = {busy_now, 7'($urandom)};
    end

    // Reference: every accepted pair must show up as an address strobe then a data strobe.
    logic [15:0] mq[$];

    function automatic strobe_t sget(input int i);
        strobe_t s;
        if (i < sq.size()) return sq[i];
        s.start = -1; s.len = -1; s.a0 = 1'bx; s.d = 8'hxx; s.fall = -1;
        return s;
    endfunction

    task automatic check_order(input int base);
        strobe_t sa;
        strobe_t sd;
        check("n_strobes", 32'(sq.size() - base), 32'(2 * mq.size()));
        foreach (mq[i]) begin
            sa = sget(base + 2 * i);
            sd = sget(base + 2 * i + 1);
            check($sformatf("p%0d_addr_a0", i), 32'(sa.a0), 32'd0);
            check($sformatf("p%0d_addr_d", i), 32'(sa.d), 32'(mq[i][15:8]));
            check($sformatf("p%0d_addr_len", i), 32'(sa.len), 32'd28);
            check($sformatf("p%0d_data_a0", i), 32'(sd.a0), 32'd1);
            check($sformatf("p%0d_data_d", i), 32'(sd.d), 32'(mq[i][7:0]));
            check($sformatf("p%0d_data_len", i), 32'(sd.len), 32'd28);
            check($sformatf("p%0d_gap", i), 32'(sd.start - sa.start), 32'd42);
        end
    endtask

    // Caller sits at a negedge; the push is presented for exactly one cycle.
    task automatic push(input logic [7:0] a, input logic [7:0] v, output logic acc, output int at);
        valid = 1'b1;
        addr  = a;
        data  = v;
        #1;
        acc = ready;
        at  = cyc;
        if (acc) mq.push_back({a, v});
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit, output int at);
        int i;
        for (i = 0; i < limit && !idle; i++) @(negedge clk);
        at = cyc;
        check(tag, 32'(idle), 32'd1);
    endtask

    int      n0;
    int      at;
    int      base;
    int      nacc;
    int      snap;
    logic    acc;
    strobe_t s;

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        flush = 1'b0;
        addr  = 8'h00;
        data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_wr_n", 32'(wr_n), 32'd1);
        rst = 1'b0;
        #1;
        check("rst_a0", 32'(a0), 32'd0);
        check("rst_d", 32'(d), 32'h00);
        check("rst_level", 32'(level), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);

        // Single pair, chip ready: exact strobe timing.
        mq.delete();
        base = sq.size();
        push(8'h08, 8'h7F, acc, n0);
        check("t1_acc", 32'(acc), 32'd1);
        wait_idle("t1_idle", 400, at);
        check_order(base);
        s = sget(base);
        check("t1_addr_start", 32'(s.start), 32'(n0 + 3));
        s = sget(base + 1);
        check("t1_data_start", 32'(s.start), 32'(n0 + 3 + 28 + 14));
        check("t1_idle_cyc", 32'(at), 32'(n0 + 3 + 28 + 14 + 28 + 64));

        // Three random pairs, BUSY held 200 cycles after every data strobe.
        mq.delete();
        base = sq.size();
        busy_auto = 1'b1;
        push(8'($urandom), 8'($urandom), acc, n0);
        for (int k = 0; k < 2; k++) push(8'($urandom), 8'($urandom), acc, at);
        wait_idle("t2_idle", 2000, at);
        check_order(base);
        s = sget(base);
        check("t2_first_start", 32'(s.start), 32'(n0 + 3));
        for (int k = 1; k < 3; k++) begin
            s = sget(base + 2 * k);
            check($sformatf("t2_after_busy%0d", k), 32'(s.start), 32'(s.fall + 1));
        end
        busy_auto = 1'b0;
        repeat (220) @(negedge clk);

        // Fill: one pair parked in the sequencer, then DEPTH+1 pushes against a busy chip.
        mq.delete();
        base = sq.size();
        busy_force = 1'b1;
        push(8'($urandom), 8'($urandom), acc, at);
        repeat (5) @(negedge clk);
        nacc = 0;
        for (int k = 0; k < 17; k++) begin
            push(8'($urandom), 8'($urandom), acc, at);
            if (acc) nacc++;
        end
        check("t3_last_refused", 32'(acc), 32'd0);
        check("t3_accepted", 32'(nacc), 32'd16);
        #1;
        check("t3_level_full", 32'(level), 32'd16);
        check("t3_ready_full", 32'(ready), 32'd0);
        busy_force = 1'b0;
        wait_idle("t3_idle", 4000, at);
        check_order(base);
        check("t3_level_end", 32'(level), 32'd0);

        // Flush during the first pair's data strobe.
        mq.delete();
        base = sq.size();
        for (int k = 0; k < 5; k++) push(8'($urandom), 8'($urandom), acc, at);
        for (int k = 0; k < 300 && !(cs_n === 1'b0 && a0 === 1'b1); k++) @(negedge clk);
        check("t4_in_data", 32'({cs_n, a0}), 32'b01);
        repeat (3) @(negedge clk);
        check("t4_level_before", 32'(level), 32'd4);
        flush = 1'b1;
        valid = 1'b1;
        addr  = 8'hA5;
        data  = 8'h5A;
        #1;
        check("t4_ready_flush", 32'(ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        valid = 1'b0;
        #1;
        check("t4_level_after", 32'(level), 32'd0);
        mq = mq[0:0];
        wait_idle("t4_idle", 400, at);
        repeat (200) @(negedge clk);
        check_order(base);

        // Reset in the middle of an address strobe.
        for (int k = 0; k < 3; k++) push(8'($urandom), 8'($urandom), acc, at);
        for (int k = 0; k < 50 && cs_n !== 1'b0; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("t5_in_strobe", 32'(cs_n), 32'd0);
        rst = 1'b1;
        #1;
        check("t5_cs_n", 32'(cs_n), 32'd1);
        check("t5_wr_n", 32'(wr_n), 32'd1);
        check("t5_level", 32'(level), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_ready", 32'(ready), 32'd1);
        snap = sq.size();
        repeat (300) @(negedge clk);
        check("t5_no_strobe", 32'(sq.size()), 32'(snap));
        check("t5_idle", 32'(idle), 32'd1);

        // Chip stuck busy with one pair queued.
        mq.delete();
        base = sq.size();
        busy_force = 1'b1;
        push(8'h20, 8'hC7, acc, n0);
`ifdef FM2151_WRQ_TIMEOUT_EN
        for (int k = 0; k < 5000 && !err; k++) @(negedge clk);
        at = cyc;
        check("t6_err", 32'(err), 32'd1);
        check("t6_err_cyc", 32'(at), 32'(n0 + 4098));
        check("t6_idle", 32'(idle), 32'd1);
        busy_force = 1'b0;
        repeat (200) @(negedge clk);
        check("t6_dropped", 32'(sq.size()), 32'(base));
        check("t6_sticky", 32'(err), 32'd1);
`else
        repeat (4200) @(negedge clk);
        check("t6_err", 32'(err), 32'd0);
        check("t6_waiting", 32'(sq.size()), 32'(base));
        check("t6_not_idle", 32'(idle), 32'd0);
        busy_force = 1'b0;
        wait_idle("t6_idle", 400, at);
        check_order(base);
`endif

        check("bus_stable", 32'(stab_bad), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
